btn_debounce: RTL and testbench



---
 rtl/btn_pkg.sv | 15 +
 rtl/btn_debounce_chan.sv | 123 ++++++++++++
 rtl/btn_debounce.sv | 33 +++
 tb/tb_btn_debounce.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // 10 ms debounce and 1 s long-press at a 100 MHz mainclk
  localparam int unsigned DEBOUNCE_10MS_100MHZ = 1000000;
  localparam int unsigned LONG_1S_100MHZ       = 100000000;

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-flop synchronizer, debounce FSM and press/release/long pulses.
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_10MS_100MHZ,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_1S_100MHZ
) (
  input  logic mainclk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_PRESS_CYCLES);

  logic              sync1, sync2;
  btn_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  // Metastability guard for the asynchronous pin
  always_ff @(posedge mainclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge mainclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  // Hold counter saturates at LONG_PRESS_CYCLES so btn_long fires once per press
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
          hold_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!sync2) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (hold_q == HOLD_FIRE) begin
          hold_d = HOLD_SAT;
          long_d = 1'b1;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (sync2) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounces NUM_BTNS independent push-buttons into clean levels and single-cycle events.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTNS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_10MS_100MHZ,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_1S_100MHZ
) (
  input  logic                mainclk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic [NUM_BTNS-1:0] btn_long
);

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_chan (
      .mainclk    (mainclk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_long   (btn_long[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16.
module tb_btn_debounce;

  localparam int unsigned NB = 4;

  logic          mainclk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_long;

  typedef struct {
    int        cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
    logic [3:0] level;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   base;

  btn_debounce #(
    .NUM_BTNS         (NB),
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(16)
  ) dut (
    .mainclk    (mainclk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #5 mainclk = ~mainclk;

  // cyc = number of rising edges so far; event "after edge N" is seen with cyc == N
  always @(posedge mainclk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h required=%h", nm, cyc, act, exp);
    end
  endfunction

  task automatic push(int c, logic [3:0] p, logic [3:0] r, logic [3:0] l, logic [3:0] lv);
    exp_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lng = l; e.level = lv;
    sb.push_back(e);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge mainclk);
  endtask

  // Monitor: any pulse is an output event and must match the scoreboard head
  exp_t m;
  always @(negedge mainclk) begin
    if ((btn_press | btn_release | btn_long) != '0) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event cyc=%0d got press=%b release=%b long=%b level=%b required no event",
                 cyc, btn_press, btn_release, btn_long, btn_level);
      end else begin
        m = sb.pop_front();
        if (m.cyc != cyc || m.press !== btn_press || m.rel !== btn_release ||
            m.lng !== btn_long || m.level !== btn_level) begin
          n_fail++;
          $display("FAIL event got cyc=%0d press=%b release=%b long=%b level=%b required cyc=%0d press=%b release=%b long=%b level=%b",
                   cyc, btn_press, btn_release, btn_long, btn_level,
                   m.cyc, m.press, m.rel, m.lng, m.level);
        end
      end
    end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
      n_chk++;
      n_fail++;
      m = sb.pop_front();
      $display("FAIL missed_event cyc=%0d got no event required cyc=%0d press=%b release=%b long=%b level=%b",
               cyc, m.cyc, m.press, m.rel, m.lng, m.level);
    end
  end

  initial begin
    rst_n   = 1'b0;
    btn_raw = 4'hF;

    // Reset with all buttons held, then held through reset release
    tick(3);
    #1 chk("reset_outputs", {btn_level, btn_press, btn_release, btn_long}, 16'h0000);
    tick(1);
    rst_n = 1'b1;
    base  = cyc;
    push(base + 7, 4'hF, 4'h0, 4'h0, 4'hF);
    tick(10);
    chk("held_level", 16'(btn_level), 16'h000F);
    btn_raw = 4'h0;
    base    = cyc;
    push(base + 7, 4'h0, 4'hF, 4'h0, 4'h0);
    tick(12);
    chk("all_released", 16'(btn_level), 16'h0000);

    // Clean press, long press and release on button 0
    btn_raw = 4'b0001;
    base    = cyc;
    push(base + 7,  4'b0001, 4'h0, 4'h0,    4'b0001);
    push(base + 23, 4'h0,    4'h0, 4'b0001, 4'b0001);
    tick(40);
    chk("btn0_level", 16'(btn_level), 16'h0001);
    btn_raw = 4'h0;
    base    = cyc;
    push(base + 7, 4'h0, 4'b0001, 4'h0, 4'h0);
    tick(12);

    // Glitches on button 1: 3-cycle and 1-cycle, both rejected
    btn_raw = 4'b0010;
    tick(3);
    btn_raw = 4'h0;
    tick(10);
    chk("glitch3_level", 16'(btn_level), 16'h0000);
    btn_raw = 4'b0010;
    tick(1);
    btn_raw = 4'h0;
    tick(10);
    chk("glitch1_level", 16'(btn_level), 16'h0000);

    // Release bounce on button 2
    btn_raw = 4'b0100;
    base    = cyc;
    push(base + 7, 4'b0100, 4'h0, 4'h0, 4'b0100);
    tick(8);
    for (int k = 0; k < 10; k++) begin
      btn_raw = (k % 2 == 1) ? 4'b0100 : 4'b0000;
      tick(2);
    end
    chk("bounce_level_held", 16'(btn_level), 16'h0004);
    btn_raw = 4'h0;
    push(base + 35, 4'h0, 4'b0100, 4'h0, 4'h0);
    tick(12);

    // Simultaneous press and release on buttons 1 and 3, short hold
    btn_raw = 4'b1010;
    base    = cyc;
    push(base + 7, 4'b1010, 4'h0, 4'h0, 4'b1010);
    tick(10);
    btn_raw = 4'h0;
    base    = cyc;
    push(base + 7, 4'h0, 4'b1010, 4'h0, 4'h0);
    tick(12);

    // Reset while button 0 is mid-debounce and button 3 is pressed
    btn_raw = 4'b1000;
    base    = cyc;
    push(base + 7, 4'b1000, 4'h0, 4'h0, 4'b1000);
    tick(10);
    btn_raw = 4'b1001;
    tick(5);
    rst_n = 1'b0;
    #1 chk("mid_reset_outputs", {btn_level, btn_press, btn_release, btn_long}, 16'h0000);
    tick(2);
    rst_n = 1'b1;
    base  = cyc;
    push(base + 7, 4'b1001, 4'h0, 4'h0, 4'b1001);
    tick(10);
    chk("post_reset_level", 16'(btn_level), 16'h0009);
    btn_raw = 4'h0;
    base    = cyc;
    push(base + 7, 4'h0, 4'b1001, 4'h0, 4'h0);
    tick(12);

    for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
    chk("scoreboard_drained", 16'(sb.size()), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
